// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: NOP encoding and loader FSM states.
package inst_rom_loader_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4
  } loader_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Word-wide instruction storage: one synchronous write port, one registered read port.
module inst_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: storage and its read register are deliberately left out of reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_rom_loader.sv
// Loads a little-endian byte stream into the instruction ROM, then runs the core and serves its fetches.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              read_enable_cpu,
  input  logic [31:0]       next_inst_addr,
  input  logic              halt,
  output logic [31:0]       inst,
  output logic              go,
  output logic [31:0]       start_pc,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_overflow,
  output logic              fetch_fault
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH_WORDS);

  loader_state_e state_q, state_d;
  logic          go_q, go_d;
  logic [ADDR_W:0] wl_q, wl_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;
  logic          ovf_q, ovf_d;
  logic          fault_q, fault_d;
  logic          use_mem_q, use_mem_d;

  logic          full, ready_c, accept, wr_en, fetch_en, fetch_ok;
  logic [31:0]   merged, fetch_off, fetch_idx, mem_rdata;

  always_comb begin
    full      = (wl_q == FULL_COUNT);
    ready_c   = ((state_q == IDLE) || (state_q == LOAD)) && !full;
    accept    = load_valid && ready_c;
    merged    = word_q | (32'(load_byte) << {byte_idx_q, 3'b000});
    wr_en     = accept && ((byte_idx_q == 2'd3) || load_last);
    fetch_off = next_inst_addr - BASE_ADDR;
    fetch_idx = fetch_off >> 2;
    fetch_en  = (state_q == RUN) && read_enable_cpu;
    // Only the loaded-word count bounds a fetch, so stale words past the program never leak out.
    fetch_ok  = (next_inst_addr[1:0] == 2'b00) && (fetch_idx < 32'(wl_q));
  end

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    wl_d       = wl_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    ovf_d      = ovf_q;
    fault_d    = fault_q;
    use_mem_d  = use_mem_q;

    if (accept) begin
      if (wr_en) begin
        word_d     = '0;
        byte_idx_d = 2'd0;
        wl_d       = wl_q + (ADDR_W+1)'(1);
      end else begin
        word_d     = merged;
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end

    unique case (state_q)
      IDLE: if (accept) state_d = load_last ? ARM : LOAD;
      LOAD: begin
        if (accept && load_last) begin
          state_d = ARM;
        end else if (full && load_valid) begin
          ovf_d = 1'b1;
          if (load_last) state_d = ARM;
        end
      end
      ARM:  state_d = RUN;
      RUN: begin
        if (fetch_en) begin
          use_mem_d = fetch_ok;
          if (!fetch_ok) fault_d = 1'b1;
        end
        if (halt) state_d = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase

    go_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      go_q       <= 1'b0;
      wl_q       <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      fault_q    <= 1'b0;
      use_mem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      wl_q       <= wl_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      ovf_q      <= ovf_d;
      fault_q    <= fault_d;
      use_mem_q  <= use_mem_d;
    end
  end

  inst_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wl_q[ADDR_W-1:0]),
    .wdata(merged),
    .re   (fetch_en && fetch_ok),
    .raddr(fetch_idx[ADDR_W-1:0]),
    .rdata(mem_rdata)
  );

  // The read register only moves on good fetches; use_mem_q selects it or the NOP for faults/reset.
  assign inst          = use_mem_q ? mem_rdata : NOP_INST;
  assign go            = go_q;
  assign load_ready    = ready_c;
  assign start_pc      = BASE_ADDR;
  assign words_loaded  = wl_q;
  assign load_overflow = ovf_q;
  assign fetch_fault   = fault_q;

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-side responder for the CPU core. Loads a program from a byte stream into an internal word ROM, then asserts go to start the core.
- Serves the core's fetch requests (next_inst_addr / read_enable_cpu) with a registered instruction word.
- Drops go when the core signals halt.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored.
- ADDR_W, 8, word-index width; log2(DEPTH_WORDS).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; also driven on start_pc.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte, little-endian within each word.
- load_last  in  1  qualifies the final byte of the program.
- load_ready  out  1  loader accepts a byte this cycle.
- read_enable_cpu  in  1  fetch request from the core.
- next_inst_addr  in  32  fetch byte address from the core.
- halt  in  1  core has completed.
- inst  out  32  fetched instruction to the core.
- go  out  1  core run enable.
- start_pc  out  32  constant BASE_ADDR.
- words_loaded  out  ADDR_W+1  count of words written.
- load_overflow  out  1  sticky: a byte was offered while the ROM was full.
- fetch_fault  out  1  sticky: misaligned or out-of-range fetch seen.

Behaviour:
- One clock domain. All state is updated on the rising edge of clk. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, go=0, inst=32'h0000_0013 (NOP), load_ready=1.
  - words_loaded=0, byte_idx=0, word shift register=0.
  - load_overflow=0, fetch_fault=0.
  - ROM array contents are not cleared.
- A byte is accepted when load_valid && load_ready.
- FSM states: IDLE, LOAD, ARM, RUN, HALTED.
- IDLE:
  - load_ready=1.
  - The first accepted byte is processed as in LOAD and moves the FSM to LOAD.
  - If that byte has load_last set, the FSM goes straight to ARM.
- LOAD:
  - Each accepted byte goes into lane byte_idx (bits 8*byte_idx+7 : 8*byte_idx). byte_idx increments mod 4.
  - On lane 3, or on a byte with load_last, the assembled word is written at index words_loaded on that same edge, and words_loaded increments.
  - Lanes not yet written in a partial final word are zero.
  - An accepted byte with load_last moves the FSM to ARM.
- Full ROM: when words_loaded==DEPTH_WORDS, load_ready=0.
  - A load_valid while full sets load_overflow. The byte is dropped.
  - Loading ends on load_last presented while full, or the FSM stays in LOAD.
  - load_last presented while full and not accepted still moves the FSM to ARM.
- ARM:
  - Lasts exactly one cycle. load_ready=0.
  - go rises on the edge that enters RUN, so go is high from the second cycle after the last byte was accepted.
- RUN:
  - go=1, load_ready=0, load_valid is ignored.
  - Fetch latency is 1 cycle: if read_enable_cpu is high at edge N, inst holds the result from edge N.
  - If read_enable_cpu is low, inst holds its value.
  - Word index = (next_inst_addr - BASE_ADDR) >> 2.
  - If next_inst_addr[1:0]!=0, or index >= words_loaded, inst=NOP and fetch_fault is set (sticky).
  - Only the words_loaded comparison is used, so stale contents beyond the loaded program are never returned.
- halt in RUN:
  - Next state is HALTED and go clears on the same edge.
  - A fetch presented in that same cycle is still served.
- HALTED:
  - go=0, load_ready=0, inst holds, fetches are ignored.
  - Exit only via reset.
- Reset at any point, including mid-word or mid-RUN, returns to the IDLE reset values. A partial word is discarded.
- Arithmetic:
  - Address subtraction is 32-bit and wraps. An address below BASE_ADDR gives a huge index, which is out of range and faults.
  - words_loaded is ADDR_W+1 bits so it can hold DEPTH_WORDS.

Decomposition:
- Shared header (alongside the core's opcode/alu_op defines):
  - NOP_INST = 32'h0000_0013.
  - Loader FSM state encodings IDLE=0, LOAD=1, ARM=2, RUN=3, HALTED=4.
- Sub-module inst_mem_array:
  - DEPTH_WORDS x 32 array with one synchronous write port and one registered read port.
  - Range and alignment checks and the NOP substitution are done in the parent.

Test Plan:
- Stream bytes 13 05 A0 00 93 05 B0 00 with last on the 8th byte -> words_loaded=2, go=1 two cycles after the last accept. A fetch at 0x0 then 0x4 returns 0x00A00513 then 0x00B00593, one cycle after each request.
- Stream 5 bytes EF BE AD DE 01 with last on byte 5 -> word1=0x00000001, words_loaded=2. A fetch at 0x8 returns NOP and sets fetch_fault.
- With DEPTH_WORDS=4, stream 20 bytes with last on byte 20 -> load_ready=0 after 16 bytes, load_overflow=1, words_loaded=4, go=1.
- In RUN, fetch at 0x2 -> inst=0x00000013 and fetch_fault=1. A later aligned fetch at 0x0 returns the stored word.
- In RUN, assert halt and read_enable_cpu at 0x4 together -> inst=word1 on that edge, go=0, later fetches leave inst unchanged.
- Assert reset after 6 bytes of a stream -> words_loaded=0, state IDLE, go=0. Reload 4 bytes 93 00 10 00 with last -> a fetch at 0x0 returns 0x00100093.
